// File: rtl/dram_segment_loader_if.sv
// DRAM read handshake (req/ack + valid) and packed-word write bus of the segment loader.
// The master modport is the loader side; the slave modport is the DRAM/target-memory side.
interface dram_segment_loader_if #(
  parameter int N_SEG           = 4,
  parameter int DRAM_ADDR_WIDTH = 18,
  parameter int DRAM_DATA_WIDTH = 32,
  parameter int MAX_BEATS       = 4,
  parameter int WR_ADDR_WIDTH   = 16
);
  localparam int SEG_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;

  logic                                 rd_req_o;
  logic [DRAM_ADDR_WIDTH-1:0]           rd_addr_o;
  logic                                 rd_ack_i;
  logic                                 rd_valid_i;
  logic [DRAM_DATA_WIDTH-1:0]           rd_data_i;
  logic                                 wr_en_o;
  logic [SEG_W-1:0]                     wr_seg_o;
  logic [WR_ADDR_WIDTH-1:0]             wr_addr_o;
  logic [MAX_BEATS*DRAM_DATA_WIDTH-1:0] wr_data_o;

  modport master (
    output rd_req_o, rd_addr_o,
    input  rd_ack_i, rd_valid_i, rd_data_i,
    output wr_en_o, wr_seg_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  rd_req_o, rd_addr_o,
    output rd_ack_i, rd_valid_i, rd_data_i,
    input  wr_en_o, wr_seg_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/dram_segment_loader.sv
// Walks N_SEG DRAM regions, packs 1..MAX_BEATS beats per word and writes them out; one read in flight,
// stalls on rd_ack_i/rd_valid_i, 2*beats+1 cycles per word at best. DSL_STALL_CNT_EN adds stall_cnt_o.
module dram_segment_loader #(
  parameter int N_SEG           = 4,
  parameter int DRAM_ADDR_WIDTH = 18,
  parameter int DRAM_DATA_WIDTH = 32,
  parameter int MAX_BEATS       = 4,
  parameter int BEAT_CNT_WIDTH  = 3,
  parameter int WR_ADDR_WIDTH   = 16
) (
  input  logic                                clk_i,
  input  logic                                general_rst_ni,
  input  logic                                start_i,
  input  logic [N_SEG*DRAM_ADDR_WIDTH-1:0]    seg_start_addr_i,
  input  logic [N_SEG*DRAM_ADDR_WIDTH-1:0]    seg_finish_addr_i,
  input  logic [N_SEG*BEAT_CNT_WIDTH-1:0]     seg_beats_i,
  dram_segment_loader_if.master               bus,
  output logic [N_SEG-1:0]                    seg_ready_o,
  output logic                                busy_o,
  output logic [2:0]                          state_o
`ifdef DSL_STALL_CNT_EN
  ,
  output logic [31:0]                         stall_cnt_o
`endif
);
  localparam int AW     = DRAM_ADDR_WIDTH;
  localparam int DW     = DRAM_DATA_WIDTH;
  localparam int BW     = BEAT_CNT_WIDTH;
  localparam int SEG_W  = (N_SEG > 1) ? $clog2(N_SEG) : 1;
  localparam int SLOT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEG_INIT = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]                   state_q, state_d;
  logic [SEG_W-1:0]             seg_q, seg_d;
  logic [AW-1:0]                rd_addr_q, rd_addr_d;
  logic [AW-1:0]                fin_q, fin_d;
  logic [WR_ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [BW-1:0]                beat_q, beat_d;
  logic [BW-1:0]                nbeats_q, nbeats_d;
  logic [MAX_BEATS-1:0][DW-1:0] pack_q, pack_d;
  logic [N_SEG-1:0]             ready_q, ready_d;

  logic [AW-1:0] cfg_start, cfg_fin;
  logic [BW-1:0] cfg_raw, cfg_beats;
  logic          start_acc, last_beat, at_fin, wr_full;

  assign cfg_start = seg_start_addr_i[seg_q*AW +: AW];
  assign cfg_fin   = seg_finish_addr_i[seg_q*AW +: AW];
  assign cfg_raw   = seg_beats_i[seg_q*BW +: BW];

  // A zero beat count still moves one beat per word; oversize counts clamp to the word width.
  always_comb begin
    cfg_beats = cfg_raw;
    if (cfg_raw == '0) begin
      cfg_beats = BW'(1);
    end else if (cfg_raw > BW'(MAX_BEATS)) begin
      cfg_beats = BW'(MAX_BEATS);
    end
  end

  assign start_acc = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
  assign last_beat = (beat_q == nbeats_q - BW'(1));
  assign at_fin    = (rd_addr_q == fin_q);
  assign wr_full   = &wr_addr_q;

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    rd_addr_d = rd_addr_q;
    fin_d     = fin_q;
    wr_addr_d = wr_addr_q;
    beat_d    = beat_q;
    nbeats_d  = nbeats_q;
    pack_d    = pack_q;
    ready_d   = ready_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          seg_d   = '0;
          ready_d = '0;
          state_d = S_SEG_INIT;
        end
      end
      S_SEG_INIT: begin
        rd_addr_d = cfg_start;
        fin_d     = cfg_fin;
        nbeats_d  = cfg_beats;
        wr_addr_d = '0;
        beat_d    = '0;
        pack_d    = '0;
        if (cfg_start > cfg_fin) begin
          ready_d[seg_q] = 1'b1;
          state_d        = S_NEXT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.rd_ack_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rd_valid_i) begin
          pack_d[beat_q[SLOT_W-1:0]] = bus.rd_data_i;
          beat_d = beat_q + BW'(1);
          if (last_beat || at_fin) begin
            state_d = S_WRITE;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
            state_d   = S_REQ;
          end
        end
      end
      S_WRITE: begin
        // wr_addr saturating at all-ones ends the segment even if DRAM words remain.
        if (at_fin || wr_full) begin
          ready_d[seg_q] = 1'b1;
          state_d        = S_NEXT;
        end else begin
          wr_addr_d = wr_addr_q + WR_ADDR_WIDTH'(1);
          rd_addr_d = rd_addr_q + AW'(1);
          beat_d    = '0;
          pack_d    = '0;
          state_d   = S_REQ;
        end
      end
      S_NEXT: begin
        if (seg_q == SEG_W'(N_SEG - 1)) begin
          state_d = S_DONE;
        end else begin
          seg_d   = seg_q + SEG_W'(1);
          state_d = S_SEG_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!general_rst_ni) begin
      state_q   <= S_IDLE;
      seg_q     <= '0;
      rd_addr_q <= '0;
      fin_q     <= '0;
      wr_addr_q <= '0;
      beat_q    <= '0;
      nbeats_q  <= '0;
      pack_q    <= '0;
      ready_q   <= '0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      rd_addr_q <= rd_addr_d;
      fin_q     <= fin_d;
      wr_addr_q <= wr_addr_d;
      beat_q    <= beat_d;
      nbeats_q  <= nbeats_d;
      pack_q    <= pack_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.rd_req_o  = (state_q == S_REQ);
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.wr_en_o   = (state_q == S_WRITE);
  assign bus.wr_seg_o  = seg_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = pack_q;
  assign seg_ready_o   = ready_q;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign state_o       = state_q;

`ifdef DSL_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (!general_rst_ni) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if ((((state_q == S_REQ) && !bus.rd_ack_i) ||
                  ((state_q == S_WAIT) && !bus.rd_valid_i)) && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif
endmodule
